mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `MEM` block between the `processor` data/fetch port (port 0) and a second bus master (port 1, loader/debug). It serialises requests, drives the `MEM` control, address and data lines for exactly one transaction at a time, and returns read data or write completion to the winning requester. It uses a round-robin grant with a registered request latch and a programmable read latency.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported MEM block.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.

module mem_arbiter_rport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     dout <= '0;
        else if (cap) dout <= din;
    end
endmodule

module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ready0,
    output logic              ready1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              gnt_id,
    output logic              busy,
    output logic              mem_read_ctrl,
    output logic              mem_write_ctrl,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read
);
    localparam int         NUM_PORTS = 2;
    localparam logic [3:0] LAT       = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t                              state;
    logic   [3:0]                        cnt;
    logic                                last_gnt;
    logic                                lat_we;
    logic   [NUM_PORTS-1:0]              rdy;
    logic   [NUM_PORTS-1:0]              cap;
    logic   [NUM_PORTS-1:0]              req;
    logic                                win;
    req_t   [NUM_PORTS-1:0]              port_req;
    logic   [NUM_PORTS-1:0][DATA_W-1:0]  rdata_q;

    assign req         = {req1, req0};
    assign port_req[0] = {we0, addr0, wdata0};
    assign port_req[1] = {we1, addr1, wdata1};

    // Round-robin: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10)      win = 1'b1;
        else if (req == 2'b11) win = ~last_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            last_gnt       <= 1'b1;
            lat_we         <= 1'b0;
            gnt_id         <= 1'b0;
            busy           <= 1'b0;
            rdy            <= '0;
            mem_read_ctrl  <= 1'b0;
            mem_write_ctrl <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        lat_we      <= port_req[win].we;
                        gnt_id      <= win;
                        last_gnt    <= win;
                        busy        <= 1'b1;
                        mem_address <= port_req[win].addr;
                        if (port_req[win].we) begin
                            mem_write_ctrl <= 1'b1;
                            mem_data_write <= port_req[win].wdata;
                        end else begin
                            mem_read_ctrl  <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read_ctrl  <= 1'b0;
                    mem_write_ctrl <= 1'b0;
                    mem_data_write <= '0;
                    if (lat_we) begin
                        mem_address  <= '0;
                        rdy[gnt_id]  <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt   <= LAT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Read data is captured by the port register on this same edge.
                    if (cnt == 4'd1) begin
                        mem_address <= '0;
                        rdy[gnt_id] <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    rdy   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            assign cap[p] = (state == WAIT) && (cnt == 4'd1) && (gnt_id == 1'(p));
            mem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
                .clk  (clk),
                .rst  (rst),
                .cap  (cap[p]),
                .din  (mem_data_read),
                .dout (rdata_q[p])
            );
        end
    endgenerate

    assign ready0 = rdy[0];
    assign ready1 = rdy[1];
    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-1 instance with a small memory
// model, plus a latency-3 instance with hand-driven read data.

module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic        ready0, ready1, gnt_id, busy, rc, wc;
    logic [31:0] rdata0, rdata1, maddr, mdw;
    logic [31:0] mdr = 0;

    logic        req0_3 = 0;
    logic [31:0] addr0_3 = 0;
    logic [31:0] mdr3 = 0;
    logic        ready0_3, ready1_3, gnt3, busy3, rc3, wc3;
    logic [31:0] rdata0_3, rdata1_3, maddr3, mdw3;

    logic        pre_we = 0;
    logic [7:0]  pre_a = 0;
    logic [31:0] pre_d = 0;
    logic [31:0] mem [256];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
        .gnt_id(gnt_id), .busy(busy),
        .mem_read_ctrl(rc), .mem_write_ctrl(wc),
        .mem_address(maddr), .mem_data_write(mdw), .mem_data_read(mdr)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0(req0_3), .we0(1'b0), .addr0(addr0_3), .wdata0(32'h0),
        .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0),
        .ready0(ready0_3), .ready1(ready1_3), .rdata0(rdata0_3), .rdata1(rdata1_3),
        .gnt_id(gnt3), .busy(busy3),
        .mem_read_ctrl(rc3), .mem_write_ctrl(wc3),
        .mem_address(maddr3), .mem_data_write(mdw3), .mem_data_read(mdr3)
    );

    // Memory with one-cycle read latency, matching MEM_LATENCY = 1.
    always @(posedge clk) begin
        if (pre_we)     mem[pre_a] <= pre_d;
        else if (wc)    mem[maddr[7:0]] <= mdw;
        if (rc)         mdr <= mem[maddr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick();
        pre_we = 1; pre_a = 8'h10; pre_d = 32'hDEADBEEF;
        tick();
        pre_we = 0;
        check("rst_strobes", {rc, wc, busy, ready0, ready1, gnt_id}, 6'b0);
        check("rst_addr", maddr, 32'h0);
        check("rst_wdata", mdw, 32'h0);
        check("rst_rdata", {rdata0, rdata1}, 64'h0);
        #3 rst = 1;
        tick();

        // single read, port 0
        req0 = 1; we0 = 0; addr0 = 32'h10;
        tick();
        check("rd_c1_rc", {rc, wc, busy}, 3'b101);
        check("rd_c1_addr", maddr, 32'h10);
        check("rd_c1_gnt", gnt_id, 1'b0);
        tick();
        check("rd_c2_rc", {rc, ready0}, 2'b00);
        check("rd_c2_addr", maddr, 32'h10);
        tick();
        check("rd_c3_ready", {ready0, ready1}, 2'b10);
        check("rd_c3_rdata0", rdata0, 32'hDEADBEEF);
        check("rd_c3_rdata1", rdata1, 32'h0);
        check("rd_c3_addr", maddr, 32'h0);
        req0 = 0;
        tick();
        check("rd_idle", {busy, ready0}, 2'b00);

        // write then read, port 1
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
        tick();
        check("wr_c1_strobe", {wc, rc}, 2'b10);
        check("wr_c1_addr", maddr, 32'h20);
        check("wr_c1_data", mdw, 32'h12345678);
        check("wr_c1_gnt", gnt_id, 1'b1);
        tick();
        check("wr_c2_ready", {ready1, ready0, wc}, 3'b100);
        check("wr_c2_data", mdw, 32'h0);
        req1 = 0;
        tick();
        req1 = 1; we1 = 0;
        tick(); tick(); tick();
        check("wr_rd_ready", ready1, 1'b1);
        check("wr_rd_rdata1", rdata1, 32'h12345678);
        check("wr_rd_rdata0", rdata0, 32'hDEADBEEF);
        req1 = 0;
        tick();

        // simultaneous requests from reset: alternate 0,1,0 with one idle bubble
        rst = 0; #2 rst = 1;
        req0 = 1; addr0 = 32'h10; req1 = 1; addr1 = 32'h20;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("rr_busy_%0d", i), busy, (i % 4) != 0);
            check($sformatf("rr_rdy_%0d", i), {ready1, ready0},
                  {(i % 8) == 7, (i % 8) == 3});
            if ((i % 4) != 0)
                check($sformatf("rr_gnt_%0d", i), gnt_id, ((i - 1) / 4) % 2);
            if (i == 3) check("rr_rdata0", rdata0, 32'hDEADBEEF);
            if (i == 7) check("rr_rdata1", rdata1, 32'h12345678);
        end
        req0 = 0; req1 = 0;
        tick();

        // reset during WAIT
        req0 = 1; addr0 = 32'h10;
        tick(); tick();
        check("mr_in_wait", {busy, rc}, 2'b10);
        rst = 0;
        #1;
        check("mr_outputs", {busy, rc, wc, ready0, ready1, gnt_id}, 6'b0);
        check("mr_addr", maddr, 32'h0);
        check("mr_rdata0", rdata0, 32'h0);
        req0 = 0;
        tick();
        check("mr_no_ready", {ready0, busy}, 2'b00);
        #3 rst = 1;
        tick();
        req1 = 1; we1 = 0; addr1 = 32'h20;
        tick();
        check("mr_r1_gnt", {busy, gnt_id, rc}, 3'b111);
        tick(); tick();
        check("mr_r1_ready", {ready1, ready0}, 2'b10);
        check("mr_r1_rdata", rdata1, 32'h12345678);
        req1 = 0;
        tick();

        // latch isolation: write then read back port 0
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
        tick();
        addr0 = 32'h44; wdata0 = 32'h55555555;
        check("li_c1_addr", maddr, 32'h30);
        check("li_c1_data", mdw, 32'hCAFEF00D);
        tick();
        check("li_c2", {ready0, wc}, 2'b10);
        check("li_c2_data", mdw, 32'h0);
        req0 = 0;
        tick();
        check("li_idle_data", mdw, 32'h0);
        req0 = 1; we0 = 0; addr0 = 32'h30;
        tick();
        addr0 = 32'h10;
        check("li_rd_data", mdw, 32'h0);
        tick();
        check("li_rd_addr", maddr, 32'h30);
        tick();
        check("li_rd_rdata", rdata0, 32'hCAFEF00D);
        req0 = 0;
        tick();

        // latency 3: data presented in the third WAIT cycle is captured
        req0_3 = 1; addr0_3 = 32'h40;
        tick();
        check("l3_c1", {rc3, busy3}, 2'b11);
        mdr3 = 32'hAAAA0009;
        tick();
        mdr3 = 32'hAAAA0001;
        check("l3_c2", {rc3, ready0_3}, 2'b00);
        tick();
        mdr3 = 32'hAAAA0002;
        check("l3_c3", ready0_3, 1'b0);
        tick();
        mdr3 = 32'hAAAA0003;
        check("l3_c4", {ready0_3, busy3}, 2'b01);
        check("l3_c4_addr", maddr3, 32'h40);
        tick();
        mdr3 = 32'hBBBB0000;
        check("l3_c5_ready", ready0_3, 1'b1);
        check("l3_c5_rdata", rdata0_3, 32'hAAAA0003);
        req0_3 = 0;
        tick();
        check("l3_idle", {busy3, ready0_3, rdata1_3 != 0}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
